// File: rtl/sample_conditioner.sv
// Three-stage sample conditioner: DC removal, decimating average, gain with saturation.
// Stage state advances only on qualified data; valid flags flow every cycle.
module sample_conditioner #(
    parameter int unsigned IN_WIDTH   = 24,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned DECIM_LOG2 = 2,
    parameter int unsigned DC_SHIFT   = 10
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic signed [IN_WIDTH-1:0]  sample_in,
    input  logic                        valid_in,
    input  logic        [3:0]           gain_in,
    input  logic                        dc_en_in,
    input  logic                        mute_in,
    input  logic                        clip_clr_in,
    output logic signed [OUT_WIDTH-1:0] sample_out,
    output logic                        valid_out,
    output logic                        clip_out
);

    localparam int unsigned X_W   = IN_WIDTH + 1;
    localparam int unsigned ACC_W = IN_WIDTH + DC_SHIFT + 1;
    localparam int unsigned S_W   = X_W + DECIM_LOG2;
    localparam int unsigned CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int unsigned SH_W  = X_W + 15;
    localparam int unsigned DROP  = IN_WIDTH - OUT_WIDTH;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic signed [SH_W-1:0] SAT_MAX =
        {{(SH_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [SH_W-1:0] SAT_MIN =
        {{(SH_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [ACC_W-1:0] dc_acc;
    logic signed [X_W-1:0]   s1_x;
    logic                    s1_v;
    logic signed [S_W-1:0]   sum;
    logic        [CNT_W-1:0] cnt;
    logic signed [X_W-1:0]   s2_avg;
    logic                    s2_v;

    logic signed [X_W-1:0]       x1_c;
    logic signed [S_W-1:0]       sum_nxt_c;
    logic signed [SH_W-1:0]      shl_c;
    logic signed [SH_W-1:0]      shr_c;
    logic signed [OUT_WIDTH-1:0] y_c;
    logic                        sat_c;
    logic                        clip_set_c;

    // Stage 1: subtract the running DC estimate
    always_comb begin
        x1_c = X_W'(sample_in);
        if (dc_en_in) begin
            x1_c = X_W'(sample_in) - X_W'(dc_acc >>> DC_SHIFT);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dc_acc <= '0;
            s1_x   <= '0;
            s1_v   <= 1'b0;
        end else begin
            s1_v <= valid_in;
            if (valid_in) begin
                s1_x   <= x1_c;
                dc_acc <= dc_en_in ? (dc_acc + ACC_W'(x1_c)) : '0;
            end
        end
    end

    // Stage 2: accumulate a group and emit its floor average
    always_comb begin
        sum_nxt_c = sum + S_W'(s1_x);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sum    <= '0;
            cnt    <= '0;
            s2_avg <= '0;
            s2_v   <= 1'b0;
        end else begin
            s2_v <= 1'b0;
            if (s1_v) begin
                if (cnt == CNT_LAST) begin
                    s2_avg <= X_W'(sum_nxt_c >>> DECIM_LOG2);
                    s2_v   <= 1'b1;
                    sum    <= '0;
                    cnt    <= '0;
                end else begin
                    sum <= sum_nxt_c;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Stage 3: gain, scale down to the output width, saturate
    always_comb begin
        shl_c = SH_W'(s2_avg) <<< gain_in;
        shr_c = shl_c >>> DROP;
        sat_c = 1'b1;
        y_c   = OUT_WIDTH'(shr_c);
        if (shr_c > SAT_MAX) begin
            y_c = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end else if (shr_c < SAT_MIN) begin
            y_c = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
        end else begin
            sat_c = 1'b0;
        end
        clip_set_c = s2_v & ~mute_in & sat_c;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sample_out <= '0;
            valid_out  <= 1'b0;
            clip_out   <= 1'b0;
        end else begin
            valid_out <= s2_v;
            clip_out  <= clip_set_c | (clip_out & ~clip_clr_in);
            if (s2_v) begin
                sample_out <= mute_in ? '0 : y_c;
            end
        end
    end

endmodule

// File: tb/tb_sample_conditioner.sv
// Bench for sample_conditioner: constant vector table, corner sequences, and
// randomized groups checked against an arithmetic reference model.
module tb_sample_conditioner;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic               rst_in      = 1'b1;
    logic signed [23:0] sample_in   = '0;
    logic               valid_in    = 1'b0;
    logic        [3:0]  gain_in     = '0;
    logic               dc_en_in    = 1'b0;
    logic               mute_in     = 1'b0;
    logic               clip_clr_in = 1'b0;
    logic signed [15:0] sample_out;
    logic               valid_out;
    logic               clip_out;

    sample_conditioner dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .sample_in   (sample_in),
        .valid_in    (valid_in),
        .gain_in     (gain_in),
        .dc_en_in    (dc_en_in),
        .mute_in     (mute_in),
        .clip_clr_in (clip_clr_in),
        .sample_out  (sample_out),
        .valid_out   (valid_out),
        .clip_out    (clip_out)
    );

    typedef struct {
        logic [15:0] val;
        logic        clip;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0][23:0] s;
        logic [3:0]       gain;
        logic             mute;
        logic [15:0]      eo;
        logic             ec;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;
    exp_t        exp_q[$];
    logic [15:0] last_out = '0;

    longint m_acc = 0;
    longint m_sum = 0;
    int     m_n   = 0;
    bit     m_clip = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Reference: spec arithmetic on wide integers, one group of four at a time
    task automatic model_feed(input logic signed [23:0] s, input int out_cyc);
        longint x;
        longint avg;
        longint y;
        exp_t   e;
        if (dc_en_in) begin
            x = longint'(s) - (m_acc >>> 10);
            m_acc = m_acc + x;
        end else begin
            x = longint'(s);
            m_acc = 0;
        end
        m_sum = m_sum + x;
        m_n++;
        if (m_n == 4) begin
            avg = m_sum >>> 2;
            y = (avg * (longint'(1) << gain_in)) >>> 8;
            if (mute_in) begin
                y = 0;
            end else if (y > 32767 || y < -32768) begin
                m_clip = 1'b1;
                y = (y > 0) ? 32767 : -32768;
            end
            e.val  = 16'(y);
            e.clip = m_clip;
            e.cyc  = out_cyc;
            exp_q.push_back(e);
            m_sum = 0;
            m_n   = 0;
        end
    endtask

    task automatic send(input logic signed [23:0] s);
        @(negedge clk_in);
        sample_in = s;
        valid_in  = 1'b1;
        model_feed(s, cyc + 3);
    endtask

    task automatic idle(input int n);
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (n - 1) @(negedge clk_in);
    endtask

    // Returns just after the edge that should raise valid_out for the last send
    task automatic wait_out();
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk_in);
        rst_in      = 1'b1;
        valid_in    = 1'b0;
        clip_clr_in = 1'b0;
        exp_q.delete();
        m_acc = 0; m_sum = 0; m_n = 0; m_clip = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // Output monitor: every valid_out must match the next model entry, on time
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (mon_en) begin
                if (rst_in) begin
                    chk("reset_outputs", {14'h0, valid_out, clip_out, sample_out}, 32'h0);
                    last_out = '0;
                end else if (valid_out) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("latency", 32'(cyc), 32'(e.cyc));
                        chk("sample", {16'h0, sample_out}, {16'h0, e.val});
                        chk("clip", {31'h0, clip_out}, {31'h0, e.clip});
                        last_out = e.val;
                    end
                end else begin
                    chk("hold", {16'h0, sample_out}, {16'h0, last_out});
                    if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                        e = exp_q.pop_front();
                        chk("missing_valid", 32'd0, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        vec_t vt[7];
        logic signed [23:0] r;

        vt[0] = '{s: {24'h000400, 24'h000300, 24'h000200, 24'h000100}, gain: 4'd0,  mute: 1'b0, eo: 16'h0002, ec: 1'b0};
        vt[1] = '{s: {24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00}, gain: 4'd0,  mute: 1'b0, eo: 16'hFFFF, ec: 1'b0};
        vt[2] = '{s: {24'h000400, 24'h000400, 24'h000400, 24'h000400}, gain: 4'd0,  mute: 1'b0, eo: 16'h0004, ec: 1'b0};
        vt[3] = '{s: {24'h000005, 24'h000003, 24'h000002, 24'h000001}, gain: 4'd15, mute: 1'b0, eo: 16'h0100, ec: 1'b0};
        vt[4] = '{s: {24'h7FFF00, 24'h7FFF00, 24'h7FFF00, 24'h7FFF00}, gain: 4'd4,  mute: 1'b1, eo: 16'h0000, ec: 1'b0};
        vt[5] = '{s: {24'h7FFF00, 24'h7FFF00, 24'h7FFF00, 24'h7FFF00}, gain: 4'd4,  mute: 1'b0, eo: 16'h7FFF, ec: 1'b1};
        vt[6] = '{s: {24'h800000, 24'h800000, 24'h800000, 24'h800000}, gain: 4'd1,  mute: 1'b0, eo: 16'h8000, ec: 1'b1};

        reset_dut();
        chk("reset_state", {14'h0, valid_out, clip_out, sample_out}, 32'h0);

        foreach (vt[i]) begin
            gain_in = vt[i].gain;
            mute_in = vt[i].mute;
            for (int j = 0; j < 4; j++) send(vt[i].s[j]);
            wait_out();
            chk($sformatf("vec%0d_valid", i), {31'h0, valid_out}, 32'd1);
            chk($sformatf("vec%0d_out", i), {16'h0, sample_out}, {16'h0, vt[i].eo});
            chk($sformatf("vec%0d_clip", i), {31'h0, clip_out}, {31'h0, vt[i].ec});
            idle(2);
        end
        mute_in = 1'b0;

        // Plain clear, then a saturating output coinciding with a clear
        @(negedge clk_in); clip_clr_in = 1'b1;
        @(negedge clk_in); clip_clr_in = 1'b0;
        m_clip = 1'b0;
        chk("clip_cleared", {31'h0, clip_out}, 32'd0);
        gain_in = 4'd4;
        for (int j = 0; j < 4; j++) send(24'h7FFF00);
        @(negedge clk_in); valid_in = 1'b0;
        @(negedge clk_in); clip_clr_in = 1'b1;
        @(posedge clk_in); #1;
        chk("set_clr_valid", {31'h0, valid_out}, 32'd1);
        chk("set_clr_clip", {31'h0, clip_out}, 32'd1);
        @(negedge clk_in); clip_clr_in = 1'b0;
        idle(3);

        // Reset in the middle of a group drops the partial sum
        gain_in = 4'd0;
        send(24'h7FFF00);
        send(24'h7FFF00);
        reset_dut();
        for (int j = 0; j < 4; j++) send(24'h000400);
        wait_out();
        chk("post_reset_valid", {31'h0, valid_out}, 32'd1);
        chk("post_reset_out", {16'h0, sample_out}, 32'h0004);
        idle(6);

        // DC tracker settles on a constant input
        dc_en_in = 1'b1;
        for (int k = 0; k < 16384; k++) send(24'h100000);
        wait_out();
        chk("dc_residual", {31'h0, (sample_out >= -16'sd1 && sample_out <= 16'sd1)}, 32'd1);
        dc_en_in = 1'b0;
        idle(4);

        // Randomized batches; settings change only while the pipeline is empty
        for (int b = 0; b < 8; b++) begin
            gain_in  = 4'($urandom_range(0, 15));
            mute_in  = ($urandom_range(0, 7) == 0);
            dc_en_in = 1'($urandom_range(0, 1));
            for (int g = 0; g < 8; g++) begin
                for (int k = 0; k < 4; k++) begin
                    r = 24'($urandom);
                    r = r >>> $urandom_range(0, 16);
                    send(r);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
            end
            idle(6);
        end
        mute_in = 1'b0;
        dc_en_in = 1'b0;
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_conditioner.md
SAMPLE_CONDITIONER -- requirements
Module: sample_conditioner

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 24, meaning raw signed sample width.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, meaning conditioned signed sample width (OUT_WIDTH < IN_WIDTH).
REQ-003 SHALL have parameter DECIM_LOG2, default 2, meaning decimation factor 2^DECIM_LOG2 (0 = no decimation).
REQ-004 SHALL have parameter DC_SHIFT, default 10, meaning DC-tracker time constant 2^DC_SHIFT input samples.
REQ-005 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port sample_in  input  IN_WIDTH  signed raw sample, qualified by valid_in.
REQ-008 SHALL have port valid_in  input  1  single-cycle strobe; may be asserted every cycle.
REQ-009 SHALL have port gain_in  input  4  left-shift gain 0..15.
REQ-010 SHALL have port dc_en_in  input  1  enables DC removal.
REQ-011 SHALL have port mute_in  input  1  forces output data to zero.
REQ-012 SHALL have port clip_clr_in  input  1  clears sticky clip flag.
REQ-013 SHALL have port sample_out  output  OUT_WIDTH  signed conditioned sample.
REQ-014 SHALL have port valid_out  output  1  single-cycle strobe qualifying sample_out.
REQ-015 SHALL have port clip_out  output  1  sticky saturation flag.

Function
REQ-016 Stage 1 (DC) SHALL, on valid_in, form x1 = sample_in - (dc_acc >>> DC_SHIFT) in IN_WIDTH+1 bits and update dc_acc += x1; dc_acc width IN_WIDTH+DC_SHIFT+1, signed.
REQ-017 With dc_en_in=0, Stage 1 SHALL pass x1 = sample_in and hold dc_acc at 0.
REQ-018 Stage 2 (decimate) SHALL accumulate 2^DECIM_LOG2 consecutive x1 values in a sum of IN_WIDTH+1+DECIM_LOG2 bits with a modulo-2^DECIM_LOG2 counter; on the last sample of a group it SHALL emit avg = sum >>> DECIM_LOG2 and restart sum at 0.
REQ-019 Stage 3 (gain/sat) SHALL compute y = (avg <<< gain_in) >>> (IN_WIDTH-OUT_WIDTH), saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and register it to sample_out.
REQ-020 gain_in, mute_in SHALL be sampled in the Stage 3 cycle; changes mid-group affect only outputs whose Stage 3 follows the change.
REQ-021 valid_out SHALL pulse exactly 3 cycles after the valid_in completing a group; one pulse per group; back-to-back groups SHALL produce back-to-back outputs without loss.
REQ-022 sample_out SHALL hold its value between valid_out pulses.
REQ-023 mute_in=1 SHALL force sample_out to 0 while valid_out still pulses; clip_out SHALL NOT set while muted.
REQ-024 clip_out SHALL set on any Stage 3 saturation and remain set until clip_clr_in; simultaneous set and clear SHALL leave clip_out=1.
REQ-025 Cycles without valid_in SHALL not advance any stage state (pipeline stalls only on data, not on output).

Reset
REQ-026 rst_in SHALL clear sample_out, valid_out, clip_out, dc_acc, sum, and group counter to 0 on the next edge.
REQ-027 rst_in mid-group SHALL discard partial sums and in-flight pipeline data; no valid_out SHALL follow for pre-reset samples.

Verification
REQ-028 Reset: hold rst_in 2 cycles -> sample_out=0, valid_out=0, clip_out=0.
REQ-029 Average: defaults, dc_en=0, gain=0, samples 0x000100,0x000200,0x000300,0x000400 -> one valid_out 3 cycles after 4th, sample_out=0x0002.
REQ-030 Saturation: gain=4, four 0x7FFF00 -> sample_out=0x7FFF, clip_out=1; gain=1, four 0x800000 -> 0x8000; clip_clr_in with new clip same cycle -> clip_out stays 1.
REQ-031 DC: dc_en=1, 16384 samples constant 0x100000 -> final |sample_out| <= 1.
REQ-032 Mute: mute=1, gain=4, four 0x7FFF00 -> valid_out pulses, sample_out=0, clip_out=0.
REQ-033 Reset mid-group: 2 samples 0x7FFF00, rst_in, then four 0x000400 -> exactly one valid_out, sample_out=0x0004.
